// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers results from NUM_FU functional units in small
// per-channel FIFOs and merges them round-robin onto one registered
// register-file write port that honours backpressure.
module wb_arbiter #(
  parameter int NUM_FU  = 2,
  parameter int DEPTH   = 2,
  parameter int DW      = 32,
  parameter int RW      = 5,
  parameter int DROP_R0 = 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        flush,
  input  logic [NUM_FU-1:0]           fu_valid,
  output logic [NUM_FU-1:0]           fu_ready,
  input  logic [NUM_FU*DW-1:0]        fu_data,
  input  logic [NUM_FU*RW-1:0]        fu_reg,
  output logic                        wb_valid,
  input  logic                        wb_ready,
  output logic [DW-1:0]               wb_data,
  output logic [RW-1:0]               wb_reg,
  output logic [$clog2(NUM_FU)-1:0]   wb_src
);

  localparam int SW = $clog2(NUM_FU);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_data [NUM_FU][DEPTH];
  logic [RW-1:0] mem_reg  [NUM_FU][DEPTH];
  logic [PW-1:0] rd_ptr   [NUM_FU];
  logic [PW-1:0] wr_ptr   [NUM_FU];
  logic [CW-1:0] count    [NUM_FU];

  logic [NUM_FU-1:0] full;
  logic [NUM_FU-1:0] empty;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic [SW-1:0]     last;
  logic [SW-1:0]     grant;
  logic              any;
  logic              adv;

  // Channel visited at round-robin distance 'step' after 'base'.
  function automatic logic [SW-1:0] rr_idx(input logic [SW-1:0] base, input int step);
    return SW'((int'(base) + step) % NUM_FU);
  endfunction

  // Per-channel FIFO status, input handshake and push qualification.
  always_comb begin
    full     = '0;
    empty    = '0;
    fu_ready = '0;
    push     = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      full[i]     = (count[i] == CW'(DEPTH));
      empty[i]    = (count[i] == '0);
      fu_ready[i] = !full[i] && !flush && !RST;
      // A write to r0 still handshakes but never occupies a FIFO slot.
      push[i]     = fu_valid[i] && fu_ready[i] &&
                    !((DROP_R0 != 0) && (fu_reg[i*RW +: RW] == '0));
    end
  end

  // Round-robin grant: first non-empty channel after the last one served.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    adv   = !wb_valid || wb_ready;
    pop   = '0;
    // Walk from farthest to nearest so the nearest candidate wins.
    for (int k = NUM_FU; k >= 1; k--) begin
      if (!empty[rr_idx(last, k)]) begin
        grant = rr_idx(last, k);
        any   = 1'b1;
      end
    end
    for (int i = 0; i < NUM_FU; i++) begin
      pop[i] = adv && any && !flush && (grant == SW'(i));
    end
  end

  // FIFO payload storage; only written on an accepted, non-dropped push.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) begin
        mem_data[i][wr_ptr[i]] <= fu_data[i*DW +: DW];
        mem_reg[i][wr_ptr[i]]  <= fu_reg[i*RW +: RW];
      end
    end
  end

  // FIFO pointers/counts, output register and round-robin pointer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_FU; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_reg   <= '0;
      wb_src   <= '0;
      last     <= SW'(NUM_FU - 1);
    end else if (flush) begin
      // The staged write is cancelled; the round-robin pointer is kept.
      for (int i = 0; i < NUM_FU; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      wb_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
        if (push[i] && !pop[i])      count[i] <= count[i] + CW'(1);
        else if (pop[i] && !push[i]) count[i] <= count[i] - CW'(1);
      end
      if (adv) begin
        if (any) begin
          wb_valid <= 1'b1;
          wb_data  <= mem_data[grant][rd_ptr[grant]];
          wb_reg   <= mem_reg[grant][rd_ptr[grant]];
          wb_src   <= grant;
          last     <= grant;
        end else begin
          wb_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (NUM_FU=2, DEPTH=2, DW=32, RW=5, DROP_R0=1).
module tb_wb_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        flush;
  logic [1:0]  fu_valid;
  logic [1:0]  fu_ready;
  logic [63:0] fu_data;
  logic [9:0]  fu_reg;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;
  logic [0:0]  wb_src;

  int n_vec = 0;
  int n_err = 0;

  wb_arbiter #(.NUM_FU(2), .DEPTH(2), .DW(32), .RW(5), .DROP_R0(1)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_data(fu_data), .fu_reg(fu_reg),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_reg(wb_reg), .wb_src(wb_src)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int i0, i1, e0, e1, nw, n;
    logic exp_src;

    RST = 1'b1; flush = 1'b0; fu_valid = '0; fu_data = '0; fu_reg = '0; wb_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", 64'(wb_valid), 64'd0);
    chk("rst_data",  64'(wb_data),  64'd0);
    chk("rst_reg",   64'(wb_reg),   64'd0);
    chk("rst_src",   64'(wb_src),   64'd0);
    chk("rst_rdy",   64'(fu_ready), 64'd0);
    RST = 1'b0; #1;
    chk("rst_rdy_rel", 64'(fu_ready), 64'd3);

    // Single push, two-cycle latency
    wb_ready = 1'b1; fu_valid = 2'b01; fu_data[31:0] = 32'hDEADBEEF; fu_reg[4:0] = 5'd7;
    tick();
    fu_valid = '0;
    chk("t1_e1_valid", 64'(wb_valid), 64'd0);
    tick();
    chk("t1_e2_valid", 64'(wb_valid), 64'd1);
    chk("t1_e2_data",  64'(wb_data),  64'hDEADBEEF);
    chk("t1_e2_reg",   64'(wb_reg),   64'd7);
    chk("t1_e2_src",   64'(wb_src),   64'd0);
    tick();
    chk("t1_e3_valid", 64'(wb_valid), 64'd0);

    // Fairness with both channels pushing 4 results
    RST = 1'b1; tick(); RST = 1'b0;
    i0 = 0; i1 = 0; e0 = 0; e1 = 0; nw = 0; exp_src = 1'b0; wb_ready = 1'b1;
    for (int c = 0; c < 40 && nw < 8; c++) begin
      fu_valid[0] = (i0 < 4); fu_data[31:0]  = 32'h100 + i0; fu_reg[4:0] = 5'(1 + i0);
      fu_valid[1] = (i1 < 4); fu_data[63:32] = 32'h200 + i1; fu_reg[9:5] = 5'(10 + i1);
      #1;
      if (fu_valid[0] && fu_ready[0]) i0++;
      if (fu_valid[1] && fu_ready[1]) i1++;
      tick();
      if (wb_valid) begin
        chk("fair_src", 64'(wb_src), 64'(exp_src));
        if (wb_src == 1'b0) begin
          chk("fair_d0", 64'(wb_data), 64'(32'h100 + e0)); e0++;
        end else begin
          chk("fair_d1", 64'(wb_data), 64'(32'h200 + e1)); e1++;
        end
        exp_src = ~exp_src;
        nw++;
      end
    end
    fu_valid = '0;
    chk("fair_count", 64'(nw), 64'd8);
    repeat (3) tick();

    // Backpressure: channel 1 pushes while the write port stalls
    wb_ready = 1'b0; n = 0;
    for (int c = 0; c < 6; c++) begin
      fu_valid[1] = 1'b1; fu_data[63:32] = 32'h300 + n; fu_reg[9:5] = 5'(20 + n);
      #1;
      if (fu_ready[1]) n++;
      tick();
    end
    chk("bp_xfers",  64'(n),           64'd3);
    chk("bp_rdy",    64'(fu_ready[1]), 64'd0);
    chk("bp_valid",  64'(wb_valid),    64'd1);
    chk("bp_data",   64'(wb_data),     64'h300);
    chk("bp_reg",    64'(wb_reg),      64'd20);
    chk("bp_src",    64'(wb_src),      64'd1);
    fu_valid = '0; wb_ready = 1'b1;
    tick();
    chk("bp_w2_data", 64'(wb_data),     64'h301);
    chk("bp_w2_rdy",  64'(fu_ready[1]), 64'd1);
    tick();
    chk("bp_w3_data", 64'(wb_data),     64'h302);
    chk("bp_w3_valid",64'(wb_valid),    64'd1);
    tick();
    chk("bp_drain",   64'(wb_valid),    64'd0);

    // Register 0 writes handshake but are dropped
    fu_valid = 2'b01; fu_data[31:0] = 32'hAAAA; fu_reg[4:0] = 5'd0;
    #1;
    chk("r0_rdy0", 64'(fu_ready[0]), 64'd1);
    tick();
    fu_data[31:0] = 32'hBBBB; fu_reg[4:0] = 5'd3;
    #1;
    chk("r0_rdy3", 64'(fu_ready[0]), 64'd1);
    tick();
    fu_valid = '0; nw = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (wb_valid) begin
        nw++;
        chk("r0_reg",  64'(wb_reg),  64'd3);
        chk("r0_data", 64'(wb_data), 64'hBBBB);
      end
    end
    chk("r0_count", 64'(nw), 64'd1);

    // Flush while stalled with buffered entries
    wb_ready = 1'b0; n = 0;
    for (int c = 0; c < 6; c++) begin
      fu_valid[0] = 1'b1; fu_data[31:0] = 32'h500 + n; fu_reg[4:0] = 5'd1;
      #1;
      if (fu_ready[0]) n++;
      tick();
    end
    fu_valid = '0;
    chk("fl_pre_xfers", 64'(n),        64'd3);
    chk("fl_pre_valid", 64'(wb_valid), 64'd1);
    flush = 1'b1; fu_valid = 2'b11; fu_data = {32'h5A5A, 32'h5B5B}; fu_reg = {5'd2, 5'd1};
    #1;
    chk("fl_rdy", 64'(fu_ready), 64'd0);
    tick();
    flush = 1'b0; fu_valid = '0;
    #1;
    chk("fl_valid", 64'(wb_valid), 64'd0);
    chk("fl_empty", 64'(fu_ready), 64'd3);
    wb_ready = 1'b1; nw = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (wb_valid) nw++;
    end
    chk("fl_no_writes", 64'(nw), 64'd0);

    // Reset in the middle of a full, stalled state
    wb_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      fu_valid = 2'b11;
      fu_data = {32'h700 + c, 32'h600 + c};
      fu_reg = {5'd9, 5'd8};
      tick();
    end
    fu_valid = '0;
    #1;
    chk("mr_full",  64'(fu_ready), 64'd0);
    chk("mr_valid", 64'(wb_valid), 64'd1);
    RST = 1'b1;
    tick();
    chk("mr_valid0", 64'(wb_valid), 64'd0);
    chk("mr_data0",  64'(wb_data),  64'd0);
    chk("mr_reg0",   64'(wb_reg),   64'd0);
    chk("mr_src0",   64'(wb_src),   64'd0);
    chk("mr_rdy_in", 64'(fu_ready), 64'd0);
    RST = 1'b0;
    #1;
    chk("mr_rdy_out", 64'(fu_ready), 64'd3);
    wb_ready = 1'b1; fu_valid = 2'b11; fu_data = {32'h900, 32'h800}; fu_reg = {5'd5, 5'd4};
    tick();
    fu_valid = '0;
    tick();
    chk("mr_g1_src",  64'(wb_src),  64'd0);
    chk("mr_g1_data", 64'(wb_data), 64'h800);
    tick();
    chk("mr_g2_src",  64'(wb_src),  64'd1);
    chk("mr_g2_data", 64'(wb_data), 64'h900);
    tick();
    chk("mr_idle", 64'(wb_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Parametrised multi-channel writeback stage: collects results from NUM_FU functional units (ALU, scalar load, and later units) over per-channel valid/ready handshakes.
- Buffers each channel in a small FIFO.
- Round-robin arbitrates onto a single registered register-file write port with backpressure.
- Replaces the fixed two-input, no-handshake writeback.

Parameters:
NUM_FU, 2, number of functional-unit input channels (>=2)
DEPTH, 2, per-channel FIFO entries (power of two, >=2)
DW, 32, result data width
RW, 5, register index width
DROP_R0, 1, when 1 writes targeting register 0 are accepted and discarded

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous active-high reset
flush  input  1  discard all buffered and staged results
fu_valid  input  NUM_FU  per-channel result valid
fu_ready  output  NUM_FU  per-channel accept
fu_data  input  NUM_FU*DW  per-channel result, channel i at [i*DW +: DW]
fu_reg  input  NUM_FU*RW  per-channel destination register, channel i at [i*RW +: RW]
wb_valid  output  1  write port valid (registered)
wb_ready  input  1  register file accepts write this cycle
wb_data  output  DW  write data (registered)
wb_reg  output  RW  write register (registered)
wb_src  output  clog2(NUM_FU)  channel that produced current write

Behaviour:
- Clocking: one clock, CLK. RST is synchronous and active-high.
- Reset (RST high at an edge):
  - All FIFOs empty.
  - wb_valid=0; wb_data, wb_reg, wb_src = 0.
  - Round-robin pointer last = NUM_FU-1, so channel 0 has first priority.
  - RST overrides flush and all handshakes; in-flight data is lost.
- Input handshake:
  - fu_ready[i] = !full[i] && !flush && !RST. It is combinational from registered state only and never depends on fu_valid.
  - Transfer on channel i when fu_valid[i] && fu_ready[i]; the entry is written at that edge.
  - If DROP_R0=1 and fu_reg is 0, the transfer completes but nothing is enqueued.
- FIFO:
  - Per-channel circular buffer with read/write pointers and count 0..DEPTH. Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - When full, fu_ready is low, so no push occurs even if a pop happens that cycle (no pass-through).
  - Order is preserved within a channel. Order across channels is set by arbitration only; the scoreboard guarantees no WAW across channels.
- Output stage:
  - Advance condition: adv = !wb_valid || wb_ready.
  - On adv, if any FIFO is non-empty:
    - Grant the first non-empty channel searching last+1, last+2, … mod NUM_FU.
    - Pop its head into wb_data/wb_reg, set wb_src to the granted channel, set wb_valid=1, and set last to the granted channel.
  - On adv with all FIFOs empty: wb_valid goes 0.
  - Without adv, all wb_* outputs hold stable. The pointer moves only on a grant.
- Latency: a transfer accepted at edge E with wb idle and no competitors gives wb_valid high after edge E+1. Minimum latency is 2 cycles; sustained throughput is 1 write/cycle while wb_ready=1.
- Fairness: with all channels continuously non-empty, grants rotate 0,1,…,NUM_FU-1,0…; no channel waits more than NUM_FU-1 grants.
- Flush:
  - At the edge with flush=1, all FIFOs empty and wb_valid=0, even if wb_ready is also high. That write is cancelled and the register file must qualify on the same flush.
  - The pointer is not changed.
  - Inputs presented during the flush cycle are not accepted (fu_ready=0).
- No assertion or error outputs; overflow is impossible by construction.

Test Plan:
1. Reset then single push: fu_valid[0]=1, fu_data=0xDEADBEEF, fu_reg=7 at edge 1 -> wb_valid=1, wb_data=0xDEADBEEF, wb_reg=7, wb_src=0 after edge 2; wb_valid=0 after edge 3 (wb_ready=1).
2. Fairness: NUM_FU=2, both channels push 4 results each back-to-back, wb_ready=1 -> wb_src sequence 0,1,0,1,0,1,0,1; each channel's data appears in push order.
3. Backpressure/full: wb_ready=0, channel 1 pushes continuously -> one entry goes to the output register, then DEPTH=2 entries fill the FIFO. fu_ready[1] drops after 3 transfers; wb outputs stay stable. Raise wb_ready -> 3 writes on consecutive cycles, with fu_ready[1] re-asserting the cycle after the first pop.
4. Register 0 drop: DROP_R0=1, push fu_reg=0 then fu_reg=3 -> both handshakes complete; only the reg 3 write appears on wb.
5. Flush mid-stall: 2 entries buffered, wb_valid=1, wb_ready=0; assert flush one cycle with fu_valid[0]=1 -> fu_ready=0 that cycle; next cycle wb_valid=0 and all FIFOs empty; no later writes appear.
6. Reset mid-operation: RST asserted while channels are full and wb_valid=1 -> after the edge, all outputs are 0, fu_ready goes all-ones once RST drops, and the first grant after a fresh push goes to channel 0.
